// File: rtl/sig_scan_engine_pkg.sv
// Shared definitions for the signature scan engine: parameter defaults,
// stream index width and FSM state encodings.
package sig_scan_engine_pkg;

    // Default maximum signature length in bytes
    localparam int SIG_MAX_DEF = 8;

    // Default width of the per-scan match counter
    localparam int CNT_W_DEF = 16;

    // Width of the running stream byte index (wraps at 2^32)
    localparam int IDX_W = 32;

    // Cycles from the accepting edge of a completing byte to its match pulse
    localparam int MATCH_LATENCY = 1;

    // Scan FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/sig_scan_engine_if.sv
// Byte-stream handshake between the RAM-side fetch stage (master) and the
// scan engine (slave).
interface sig_scan_engine_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/sig_window_cmp.sv
// Combinational comparator: window[0] is the newest byte, so the newest len
// bytes match when window[k] == signature[len-1-k] for every k < len.
module sig_window_cmp
    import sig_scan_engine_pkg::*;
#(
    parameter int SIG_MAX = SIG_MAX_DEF
) (
    input  logic [7:0]               window    [SIG_MAX],
    input  logic [7:0]               signature [SIG_MAX],
    input  logic [$clog2(SIG_MAX):0] len,
    output logic                     hit
);

    // A zero or oversized length can never hit; otherwise every paired byte must agree
    always_comb begin
        hit = (len != '0) && (int'(len) <= SIG_MAX);
        for (int k = 0; k < SIG_MAX; k++) begin
            for (int j = 0; j < SIG_MAX; j++) begin
                if ((k + j == int'(len) - 1) && (window[k] != signature[j])) begin
                    hit = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sig_scan_engine.sv
// Signature scan engine: holds a programmable byte signature, scans an
// incoming byte stream and reports every (possibly overlapping) hit.
module sig_scan_engine
    import sig_scan_engine_pkg::*;
#(
    parameter int SIG_MAX = SIG_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                       clk_cpu,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [$clog2(SIG_MAX)-1:0] cfg_adrs,
    input  logic [7:0]                 cfg_data,
    input  logic [$clog2(SIG_MAX):0]   cfg_len,
    input  logic                       start,
    sig_scan_engine_if.slave           stream,
    output logic                       busy,
    output logic                       match,
    output logic [IDX_W-1:0]           match_offset,
    output logic [CNT_W-1:0]           match_count,
    output logic                       done
);

    localparam int LEN_W = $clog2(SIG_MAX) + 1;

    scan_state_e      state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] fill_q, fill_d, fill_inc;
    logic [7:0]       sig_q [SIG_MAX];
    logic [7:0]       sig_d [SIG_MAX];
    logic [7:0]       win_q [SIG_MAX];
    logic [7:0]       win_d [SIG_MAX];
    logic [7:0]       win_shift [SIG_MAX];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] match_offset_q, match_offset_d;
    logic [CNT_W-1:0] match_count_q, match_count_d;
    logic             match_q, match_d;
    logic             done_q, done_d;
    logic             accept;
    logic             cmp_hit;
    logic             hit;

    assign stream.in_ready = (state_q == ST_SCAN);
    assign accept          = (state_q == ST_SCAN) && stream.in_valid;

    // Window and fill count as they would look after accepting the current byte
    always_comb begin
        win_shift[0] = stream.in_data;
        for (int k = 1; k < SIG_MAX; k++) begin
            win_shift[k] = win_q[k-1];
        end
        fill_inc = (fill_q == LEN_W'(SIG_MAX)) ? fill_q : fill_q + 1'b1;
    end

    sig_window_cmp #(
        .SIG_MAX (SIG_MAX)
    ) u_cmp (
        .window    (win_shift),
        .signature (sig_q),
        .len       (len_q),
        .hit       (cmp_hit)
    );

    assign hit = accept && cmp_hit && (fill_inc >= len_q);

    // Next-state logic for the FSM, signature store, window and counters
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        sig_d          = sig_q;
        win_d          = win_q;
        fill_d         = fill_q;
        idx_d          = idx_q;
        match_offset_d = match_offset_q;
        match_count_d  = match_count_q;
        match_d        = 1'b0;
        done_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    sig_d[cfg_adrs] = cfg_data;
                end
                if (start) begin
                    len_d         = cfg_len;
                    fill_d        = '0;
                    idx_d         = '0;
                    match_count_d = '0;
                    for (int k = 0; k < SIG_MAX; k++) begin
                        win_d[k] = 8'h00;
                    end
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (accept) begin
                    win_d  = win_shift;
                    fill_d = fill_inc;
                    idx_d  = idx_q + 1'b1;
                    if (hit) begin
                        match_d        = 1'b1;
                        match_offset_d = idx_q - IDX_W'(len_q) + 1'b1;
                        if (match_count_q != '1) begin
                            match_count_d = match_count_q + 1'b1;
                        end
                    end
                    if (stream.in_last) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear of all scan and signature state
    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            fill_q         <= '0;
            idx_q          <= '0;
            match_offset_q <= '0;
            match_count_q  <= '0;
            match_q        <= 1'b0;
            done_q         <= 1'b0;
            for (int k = 0; k < SIG_MAX; k++) begin
                sig_q[k] <= 8'h00;
                win_q[k] <= 8'h00;
            end
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            fill_q         <= fill_d;
            idx_q          <= idx_d;
            match_offset_q <= match_offset_d;
            match_count_q  <= match_count_d;
            match_q        <= match_d;
            done_q         <= done_d;
            sig_q          <= sig_d;
            win_q          <= win_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign match        = match_q;
    assign match_offset = match_offset_q;
    assign match_count  = match_count_q;
    assign done         = done_q;

endmodule

// File: doc/sig_scan_engine.md
SIG_SCAN_ENGINE -- requirements
Module: sig_scan_engine

Interface
REQ-001 SHALL have parameter SIG_MAX, default 8, meaning maximum signature length in bytes.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the match counter.
REQ-003 SHALL have port clk_cpu, input, 1, sole clock; all logic samples on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = asserted).
REQ-005 SHALL have port cfg_we, input, 1, signature byte write strobe.
REQ-006 SHALL have port cfg_adrs, input, clog2(SIG_MAX), signature byte index.
REQ-007 SHALL have port cfg_data, input, 8, signature byte value.
REQ-008 SHALL have port cfg_len, input, clog2(SIG_MAX)+1, signature length, sampled at start.
REQ-009 SHALL have port start, input, 1, begin a new scan.
REQ-010 SHALL have ports in_valid (input, 1), in_data (input, 8), in_last (input, 1), in_ready (output, 1): byte-stream handshake from the RAM-side fetch stage.
REQ-011 SHALL have port busy, output, 1, scan in progress.
REQ-012 SHALL have port match, output, 1, one-cycle pulse per signature hit.
REQ-013 SHALL have port match_offset, output, 32, stream offset of the first byte of the hit.
REQ-014 SHALL have port match_count, output, CNT_W, hits in the current scan.
REQ-015 SHALL have port done, output, 1, one-cycle end-of-scan pulse.

Function
REQ-016 SHALL implement FSM IDLE -> SCAN (start) -> DONE (in_last accepted) -> IDLE (next cycle).
REQ-017 SHALL drive in_ready=1 only in SCAN; a byte is accepted when in_valid && in_ready.
REQ-018 SHALL write cfg_data into signature slot cfg_adrs on cfg_we only in IDLE; writes in SCAN/DONE are ignored.
REQ-019 SHALL ignore start outside IDLE.
REQ-020 SHALL, on start, latch cfg_len, clear the byte window, the fill counter, the byte index (to 0), and match_count.
REQ-021 SHALL shift each accepted byte into a SIG_MAX-byte window and increment the 32-bit byte index, wrapping at 2^32.
REQ-022 SHALL flag a hit when the newest len window bytes equal signature bytes 0..len-1 in stream order and at least len bytes have been accepted this scan.
REQ-023 SHALL never hit when latched len is 0 or greater than SIG_MAX.
REQ-024 SHALL pulse match exactly one cycle after the accepting edge of the completing byte, with match_offset = index_of_completing_byte - len + 1 (mod 2^32).
REQ-025 SHALL report overlapping hits individually (every qualifying byte produces a pulse).
REQ-026 SHALL increment match_count on each hit, saturating at 2^CNT_W-1; match_count holds after done until the next start.
REQ-027 SHALL assert done in the DONE cycle, coincident with any match produced by the last byte.
REQ-028 SHALL drive busy=1 in SCAN and DONE, 0 in IDLE.
REQ-029 SHALL hold match_offset at its last value when match=0.

Reset
REQ-030 SHALL, on reset=0 at any time (including mid-scan), asynchronously enter IDLE with in_ready, busy, match, done = 0, match_offset = 0, match_count = 0, window and fill counter cleared.
REQ-031 SHALL clear signature storage and latched len to 0 on reset.

Structure
REQ-032 SHALL place FSM state encodings and the SIG_MAX/CNT_W defaults in the shared defines file alongside the existing cycle constants.
REQ-033 SHALL implement the window comparator as one sub-module, sig_window_cmp (window, signature, len in; hit out), purely combinational; FSM, counters and registers stay in the top.

Verification
REQ-034 Signature "VIRU" (len 4), stream "xxVIRUSx" with in_last on final byte -> one match, match_offset=2, match_count=1, done one cycle after last byte accepted.
REQ-035 Signature "AA" (len 2), stream "AAAA" -> three match pulses, offsets 0,1,2, match_count=3.
REQ-036 len 4, stream of 3 bytes equal to signature prefix with in_last -> no match, done=1, match_count=0.
REQ-037 in_valid toggled every other cycle over "xVIRU" -> same single hit at offset 1; no byte accepted while in_valid=0; cfg_we during SCAN leaves signature unchanged.
REQ-038 reset driven low for 1 cycle mid-scan after 3 bytes -> all outputs 0, in_ready=0 immediately; new start with same stream reports offsets from 0.
REQ-039 len 0 and len SIG_MAX+1, any stream -> zero matches; CNT_W=2 with 5 hits -> match_count saturates at 3.
